// File: rtl/toggle_decoder_pkg.sv
// Shared definitions for the toggle link receiver: FSM state encodings and
// default parameter values.
package toggle_decoder_pkg;

    localparam int SYNC_STAGES_DEF   = 2;
    localparam int FILTER_CYCLES_DEF = 4;
    localparam int CNT_W_DEF         = 8;

    // Bit 0 follows the candidate level, bit 1 the accepted level.
    localparam logic [1:0] S_LOW    = 2'b00;
    localparam logic [1:0] S_QUAL_H = 2'b01;
    localparam logic [1:0] S_HIGH   = 2'b11;
    localparam logic [1:0] S_QUAL_L = 2'b10;

endpackage

// File: rtl/sync_chain.sv
// N-stage synchronizer for a single asynchronous input, cleared to 0 by an
// asynchronous active-low reset.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr_p0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_p0 <= '0;
        end else begin
            sr_p0 <= {sr_p0[STAGES-2:0], d};
        end
    end

    assign q = sr_p0[STAGES-1];

endmodule

// File: rtl/toggle_decoder.sv
// Toggle link receiver: synchronizes t_in, filters short excursions and turns
// every accepted level change into a one-cycle pulse plus an event count.
module toggle_decoder
    import toggle_decoder_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             t_in,
    input  logic             clr,
    output logic             pulse,
    output logic             level,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic             glitch
);

    localparam int              FC_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

    logic            s;
    logic [1:0]      state, state_nx;
    logic [FC_W-1:0] fc, fc_nx;
    logic            accept, reject;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (t_in),
        .q   (s)
    );

    always_comb begin
        state_nx = state;
        fc_nx    = fc;
        accept   = 1'b0;
        reject   = 1'b0;
        case (state)
            S_LOW: begin
                if (s) begin
                    if (FILTER_CYCLES == 1) begin
                        state_nx = S_HIGH;
                        accept   = 1'b1;
                    end else begin
                        state_nx = S_QUAL_H;
                        fc_nx    = FC_ONE;
                    end
                end
            end
            S_QUAL_H: begin
                if (!s) begin
                    state_nx = S_LOW;
                    fc_nx    = '0;
                    reject   = 1'b1;
                end else if (fc == FC_LAST) begin
                    state_nx = S_HIGH;
                    fc_nx    = '0;
                    accept   = 1'b1;
                end else begin
                    fc_nx = fc + FC_ONE;
                end
            end
            S_HIGH: begin
                if (!s) begin
                    if (FILTER_CYCLES == 1) begin
                        state_nx = S_LOW;
                        accept   = 1'b1;
                    end else begin
                        state_nx = S_QUAL_L;
                        fc_nx    = FC_ONE;
                    end
                end
            end
            S_QUAL_L: begin
                if (s) begin
                    state_nx = S_HIGH;
                    fc_nx    = '0;
                    reject   = 1'b1;
                end else if (fc == FC_LAST) begin
                    state_nx = S_LOW;
                    fc_nx    = '0;
                    accept   = 1'b1;
                end else begin
                    fc_nx = fc + FC_ONE;
                end
            end
            default: begin
                state_nx = S_LOW;
                fc_nx    = '0;
            end
        endcase
    end

    // Stage boundary: FSM, event outputs and counter all register here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_LOW;
            fc     <= '0;
            level  <= 1'b0;
            pulse  <= 1'b0;
            glitch <= 1'b0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_nx;
            fc     <= fc_nx;
            pulse  <= accept;
            glitch <= reject;
            if (accept) begin
                level <= ~level;
            end
            // A clear that lands on an accept still records that event.
            if (clr) begin
                count <= accept ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
                ovf   <= 1'b0;
            end else if (accept) begin
                count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
                if (&count) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule
